mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus: mem_a, mem_wr, write data and read data.
- Contains the 128 KB byte RAM, the 0x30000 byte-I/O port (rx and tx FIFOs toward the UART), the 0x30004 cycle counter and program-stop flag.
- Drives the CPU's rdy_in so the core freezes while an I/O access cannot complete.
- Sits between the cpu top and the UART/board wrapper.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB).
RX_DEPTH, 16, rx FIFO entries (power of 2, >= 2).
TX_DEPTH, 16, tx FIFO entries (power of 2, >= 2).

Ports:
clk_in  in  1  system clock; all state updates on rising edge.
rst_in  in  1  asynchronous, active-low reset.
mem_a  in  32  CPU address; only [17:0] decoded.
mem_wr  in  1  1 = write, 0 = read; a read is performed every cycle mem_wr=0.
mem_wdata  in  8  CPU write data (CPU mem_dout).
mem_rdata  out  8  read data to CPU mem_din; registered.
cpu_rdy  out  1  to CPU rdy_in; low stalls the access.
rx_data  in  8  byte from UART receiver.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  rx FIFO not full.
tx_data  out  8  head of tx FIFO.
tx_valid  out  1  tx FIFO not empty.
tx_ready  in  1  UART transmitter accepts tx_data.
prog_done  out  1  sticky; set by a write to 0x30004.

Behaviour:
- Reset (rst_in=0, async):
  - Outputs: mem_rdata=0, prog_done=0, both FIFOs empty (tx_valid=0, rx_ready=1), cycle counter=0, snapshot=0.
  - RAM contents are not cleared.
- Decode:
  - io = mem_a[17:16]==2'b11.
  - ram = mem_a[17]==0; RAM index is mem_a[16:0].
  - hole = mem_a[17:16]==2'b10: reads return 0x00, writes are ignored.
- Read latency:
  - Address presented in cycle N (mem_wr=0, cpu_rdy=1); mem_rdata holds the byte from cycle N+1 until the next accepted read.
  - When cpu_rdy=0, mem_rdata holds its previous value.
- Write: takes effect at the edge ending cycle N when cpu_rdy=1; mem_rdata is unchanged.
- Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF->0.
- I/O map (low 3 bits of mem_a when io):
  - 0 read: pop rx FIFO head into mem_rdata. Each accepted read cycle pops exactly one byte.
  - 0 write: push mem_wdata to tx FIFO. A write of 0x00 is ignored (no push, no stall).
  - 4 read: mem_rdata = counter[7:0] at that edge; snapshot <= counter.
  - 5, 6, 7 read: snapshot bytes 1, 2, 3. The snapshot is unchanged.
  - 4 write: prog_done <= 1 (sticky until reset). No tx push.
  - Other io offsets: read 0x00, write ignored.
- cpu_rdy (combinational) = NOT(rd0 AND rx_empty) AND NOT(wr0_nonzero AND tx_full).
  - While low, nothing pops, pushes, writes or snapshots for that access.
  - The counter keeps running while cpu_rdy is low.
- FIFOs: circular buffers with pointer wrap plus count.
  - rx push when rx_valid & rx_ready; tx pop when tx_valid & tx_ready.
  - Full/empty are evaluated on pre-edge state:
    - A push into an empty rx FIFO is not forwarded to a read in the same cycle; that read stalls one cycle.
    - A full tx FIFO with a simultaneous tx pop still stalls the CPU write that cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- Reset mid-stall: FIFOs empty and cpu_rdy follows the new state immediately.

Test Plan:
- RAM: write 0xA5 @0x00010, then read 0x00010 in cycle N -> mem_rdata=0xA5 from N+1. Read 0x1FFFF after writing 0x3C there -> 0x3C. Read 0x20000 -> 0x00.
- rx stall:
  - Read 0x30000 with rx empty -> cpu_rdy=0.
  - Push 0x41 -> cpu_rdy goes high the following cycle; mem_rdata=0x41 one cycle after acceptance.
  - FIFO empty again.
- tx backpressure:
  - With tx_ready=0, write 0x01..0x10 -> 16 accepted; the 17th write of 0x11 -> cpu_rdy=0.
  - Raise tx_ready -> tx_data order 0x01..0x11, each exactly once.
  - A write of 0x00 -> no push.
- Counter: 100 cycles after reset, read 0x30004, then 0x30005, 0x30006, 0x30007 -> the four bytes equal the snapshot taken at the 0x30004 read edge, unaffected by later counts.
- Done/reset: write 0x30004 -> prog_done=1 and stays 1. Assert rst_in=0 asynchronously during an rx stall -> prog_done=0, rx_ready=1, tx_valid=0 immediately.

Source files
------------

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM, rx/tx byte FIFOs
// toward the UART, a free-running cycle counter with snapshot, and a sticky stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        cpu_rdy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_done
);
  localparam int RXP_W = $clog2(RX_DEPTH);
  localparam int TXP_W = $clog2(TX_DEPTH);
  localparam logic [RXP_W:0] RX_FULL = (RXP_W+1)'(RX_DEPTH);
  localparam logic [TXP_W:0] TX_FULL = (TXP_W+1)'(TX_DEPTH);

  logic [7:0] ram_mem [2**RAM_ADDR_W];
  logic [7:0] rx_mem  [RX_DEPTH];
  logic [7:0] tx_mem  [TX_DEPTH];

  logic [RXP_W-1:0] rx_wp, rx_rp;
  logic [RXP_W:0]   rx_cnt;
  logic [TXP_W-1:0] tx_wp, tx_rp;
  logic [TXP_W:0]   tx_cnt;
  logic [31:0]      cyc_cnt, snap;

  logic       io_sel, ram_sel;
  logic [2:0] io_off;
  logic       rd0, wr0_nz, wr4;
  logic       rx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop, ram_we, rd_acc;
  logic [7:0] rd_mux_p0;
  logic       unused_a;

  assign unused_a = ^mem_a[31:18];

  assign io_sel  = (mem_a[17:16] == 2'b11);
  assign ram_sel = ~mem_a[17];
  assign io_off  = mem_a[2:0];

  assign rd0    = io_sel & ~mem_wr & (io_off == 3'd0);
  assign wr0_nz = io_sel &  mem_wr & (io_off == 3'd0) & (mem_wdata != 8'h00);
  assign wr4    = io_sel &  mem_wr & (io_off == 3'd4);

  // Full/empty come from pre-edge state only: no same-cycle forwarding.
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL);
  assign cpu_rdy  = ~(rd0 & rx_empty) & ~(wr0_nz & tx_full);

  assign rx_ready = (rx_cnt != RX_FULL);
  assign tx_valid = (tx_cnt != '0);
  assign tx_data  = tx_mem[tx_rp];

  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = rd0 & cpu_rdy;
  assign tx_push = wr0_nz & cpu_rdy;
  assign tx_pop  = tx_valid & tx_ready;
  assign ram_we  = ram_sel & mem_wr & cpu_rdy;
  assign rd_acc  = ~mem_wr & cpu_rdy;

  always_comb begin
    rd_mux_p0 = 8'h00;
    if (ram_sel) begin
      rd_mux_p0 = ram_mem[mem_a[RAM_ADDR_W-1:0]];
    end else if (io_sel) begin
      case (io_off)
        3'd0:    rd_mux_p0 = rx_mem[rx_rp];
        3'd4:    rd_mux_p0 = cyc_cnt[7:0];
        3'd5:    rd_mux_p0 = snap[15:8];
        3'd6:    rd_mux_p0 = snap[23:16];
        3'd7:    rd_mux_p0 = snap[31:24];
        default: rd_mux_p0 = 8'h00;
      endcase
    end
  end

  // Storage arrays carry no reset; only pointers and counts are cleared.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram_mem[mem_a[RAM_ADDR_W-1:0]] <= mem_wdata;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
    if (tx_push) tx_mem[tx_wp] <= mem_wdata;
  end

  // ---- p0 -> p1: registered read data, counter, flags and FIFO control ----
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_rdata <= 8'h00;
      prog_done <= 1'b0;
      cyc_cnt   <= 32'h0;
      snap      <= 32'h0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (rd_acc) mem_rdata <= rd_mux_p0;
      if (rd_acc && io_sel && io_off == 3'd4) snap <= cyc_cnt;
      if (wr4) prog_done <= 1'b1;

      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase

      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end
endmodule
